// File: rtl/load_store_unit_if.sv
// Bus bundle between the MEM stage / data memory environment and load_store_unit.
// Handshake: a request transfers on a rising edge where req_valid and req_ready
// are both high; the requester must hold all req_* fields stable while
// req_valid is high and req_ready is low. rsp_valid is a one-cycle completion
// pulse with no back-pressure. The mem_* group is the raw data-memory port
// (cs, WR_RD: 1 = read / 0 = write, ADDR, din, dout one cycle after a read).
interface load_store_unit_if #(
    parameter int ADDR_WIDTH = 10
) ();
    logic                  req_valid;
    logic                  req_ready;
    logic                  req_we;
    logic [1:0]            req_size;
    logic                  req_signed;
    logic [ADDR_WIDTH+1:0] req_addr;
    logic [31:0]           req_wdata;
    logic                  rsp_valid;
    logic [31:0]           rsp_rdata;
    logic                  rsp_exc;
    logic                  mem_cs;
    logic                  mem_wr_rd;
    logic [ADDR_WIDTH-1:0] mem_addr;
    logic [31:0]           mem_din;
    logic [31:0]           mem_dout;

    // The unit itself.
    modport slave (
        input  req_valid, req_we, req_size, req_signed, req_addr, req_wdata, mem_dout,
        output req_ready, rsp_valid, rsp_rdata, rsp_exc,
        output mem_cs, mem_wr_rd, mem_addr, mem_din
    );

    // Pipeline plus data memory side.
    modport master (
        output req_valid, req_we, req_size, req_signed, req_addr, req_wdata, mem_dout,
        input  req_ready, rsp_valid, rsp_rdata, rsp_exc,
        input  mem_cs, mem_wr_rd, mem_addr, mem_din
    );
endinterface

// File: rtl/load_store_unit.sv
// load_store_unit: byte/half/word loads and stores onto a 32-bit word-addressed
// data memory with a 1-cycle registered read. Sub-word stores use a
// read-modify-write. Optional macro LSU_MISALIGN_EXC_EN: misaligned requests
// complete with rsp_exc instead of being silently aligned down.
// dbg_state exposes the FSM state (IDLE=0 RD=1 RESP=2 MRG=3 WR=4 EXC=5).
module load_store_unit #(
    parameter int ADDR_WIDTH = 10,
    parameter int DATA_WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    load_store_unit_if.slave bus,
    output logic [2:0]       dbg_state
);
    typedef enum logic [2:0] {
        IDLE = 3'd0,
        RD   = 3'd1,
        RESP = 3'd2,
        MRG  = 3'd3,
        WR   = 3'd4,
        EXC  = 3'd5
    } state_t;

    state_t                  state_q, state_d;
    logic                    we_q, signed_q;
    logic [1:0]              size_q, off_q;
    logic [ADDR_WIDTH-1:0]   addr_q;
    logic [DATA_WIDTH-1:0]   wdata_q, din_q, rdata_q;

    logic                    accept, misalign;
    logic [1:0]              size_n, off_n;
    logic [4:0]              sh;
    logic [DATA_WIDTH-1:0]   shifted, load_ext, lane_mask, merged;

    assign accept = bus.req_valid & bus.req_ready;

    // Normalise the incoming request: size 11 is a word, misaligned offsets align down.
    always_comb begin
        size_n   = (bus.req_size == 2'b11) ? 2'b10 : bus.req_size;
        misalign = ((size_n == 2'b01) && bus.req_addr[0]) ||
                   ((size_n == 2'b10) && (bus.req_addr[1:0] != 2'b00));
        case (size_n)
            2'b00:   off_n = bus.req_addr[1:0];
            2'b01:   off_n = {bus.req_addr[1], 1'b0};
            default: off_n = 2'b00;
        endcase
    end

    // Lane extraction for loads and lane merge for sub-word stores.
    always_comb begin
        sh       = {off_q, 3'b000};
        shifted  = bus.mem_dout >> sh;
        case (size_q)
            2'b00: begin
                load_ext  = {{24{signed_q & shifted[7]}}, shifted[7:0]};
                lane_mask = 32'h0000_00FF << sh;
            end
            2'b01: begin
                load_ext  = {{16{signed_q & shifted[15]}}, shifted[15:0]};
                lane_mask = 32'h0000_FFFF << sh;
            end
            default: begin
                load_ext  = bus.mem_dout;
                lane_mask = 32'hFFFF_FFFF;
            end
        endcase
        merged = (bus.mem_dout & ~lane_mask) | ((wdata_q << sh) & lane_mask);
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (accept) begin
`ifdef LSU_MISALIGN_EXC_EN
                    if (misalign)
                        state_d = EXC;
                    else
`endif
                    if (bus.req_we && (size_n == 2'b10))
                        state_d = WR;
                    else
                        state_d = RD;
                end
            end
            RD:      state_d = we_q ? MRG : RESP;
            RESP:    state_d = IDLE;
            MRG:     state_d = WR;
            WR:      state_d = IDLE;
            EXC:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Outputs decoded from state; memory and handshake strobes are masked during reset.
    always_comb begin
        bus.req_ready = (state_q == IDLE) && !rst;
        bus.mem_cs    = ((state_q == RD) || (state_q == WR)) && !rst;
        bus.mem_wr_rd = (state_q != WR);
        bus.mem_addr  = addr_q;
        bus.mem_din   = din_q;
        bus.rsp_valid = ((state_q == RESP) || (state_q == WR) || (state_q == EXC)) && !rst;
`ifdef LSU_MISALIGN_EXC_EN
        bus.rsp_exc   = (state_q == EXC) && !rst;
`else
        bus.rsp_exc   = 1'b0;
`endif
        if (state_q == RESP)
            bus.rsp_rdata = load_ext;
        else if ((state_q == WR) || (state_q == EXC))
            bus.rsp_rdata = '0;
        else
            bus.rsp_rdata = rdata_q;
        dbg_state = state_q;
    end

    // State register, request capture, merge register and held response data.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            we_q     <= 1'b0;
            signed_q <= 1'b0;
            size_q   <= 2'b00;
            off_q    <= 2'b00;
            addr_q   <= '0;
            wdata_q  <= '0;
            din_q    <= '0;
            rdata_q  <= '0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                we_q     <= bus.req_we;
                signed_q <= bus.req_signed;
                size_q   <= size_n;
                off_q    <= off_n;
                wdata_q  <= bus.req_wdata;
            end
            // Address only moves for requests that really touch memory.
            if (accept && ((state_d == RD) || (state_d == WR)))
                addr_q <= bus.req_addr[ADDR_WIDTH+1:2];
            if (accept && (state_d == WR))
                din_q <= bus.req_wdata;
            else if (state_q == MRG)
                din_q <= merged;
            if (bus.rsp_valid)
                rdata_q <= bus.rsp_rdata;
        end
    end
endmodule
